// File: rtl/bus_pkg.sv
// Shared bus definitions: register offsets, responder FSM state codes, transfer direction.
// Imported by the FIFO responder and the memory model on the same processor bus.
// No ports; constants only.
package bus_pkg;

  // Word offsets inside a 4-word peripheral window
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_CLRERR = 2'd3;

  // Responder FSM state codes
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // wr_rd encoding
  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

endpackage

// File: rtl/bus_fifo_responder_if.sv
// Processor valid/ready memory bus, one initiator and one responder.
// Signals: addr_i, wdata_i, wr_rd_i, valid_i (initiator -> responder);
//          rdata_o, ready_o (responder -> initiator, ready_o is a one-cycle completion pulse).
interface bus_fifo_responder_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int WIDTH      = 16
);
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [WIDTH-1:0]      wdata_i;
  logic                  wr_rd_i;
  logic                  valid_i;
  logic [WIDTH-1:0]      rdata_o;
  logic                  ready_o;

  modport master (
    output addr_i, wdata_i, wr_rd_i, valid_i,
    input  rdata_o, ready_o
  );

  modport slave (
    input  addr_i, wdata_i, wr_rd_i, valid_i,
    output rdata_o, ready_o
  );
endinterface

// File: rtl/bus_fifo_responder_sync.sv
// Synchronous FIFO with flush; head word is read straight from the storage array.
// Ports: clk/rst, push/push_data, pop, flush -> full, empty, count (0..FIFO_DEPTH), head.
// A pop on empty is ignored; a push on full only lands if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);
  localparam int PW = CW - 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));

  // Flush dominates; a push into a full FIFO is accepted only when a pop frees the slot
  // this same cycle (wr_ptr == rd_ptr then, so the new word becomes the tail).
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/bus_fifo_responder.sv
// Memory-mapped FIFO peripheral on the valid/ready processor bus (4 words at BASE_ADDR),
// ready_o pulses WAIT_STATES+1 cycles after valid_i is sampled; side effects commit on that edge.
// Ports: clk_i/rst_i, bus (slave modport), pop_data_o/pop_valid_o/pop_i consumer port, irq_o.
module bus_fifo_responder
  import bus_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WIDTH       = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int BASE_ADDR   = 'h3F0,
  parameter int WAIT_STATES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  bus_fifo_responder_if.slave bus,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             pop_valid_o,
  input  logic             pop_i,
  output logic             irq_o
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [WIDTH-1:0]      lat_wdata;
  logic                  lat_wr;

  logic [CW-1:0]    threshold;
  logic             ovf;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head;

  logic             commit;
  logic             hit;
  logic [1:0]       off;
  logic             wr_commit;
  logic             push;
  logic             flush;
  logic [WIDTH-1:0] rd_mux;

  // Bus FSM: the request is latched in IDLE so the initiator's later changes are irrelevant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wr    <= RD;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_i) begin
            lat_addr  <= bus.addr_i;
            lat_wdata <= bus.wdata_i;
            lat_wr    <= bus.wr_rd_i;
            wait_cnt  <= '0;
            state     <= (WAIT_STATES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          if (wait_cnt == WS_LAST) state <= RESP;
          else                     wait_cnt <= wait_cnt + 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Decode of the latched request; unmapped addresses complete with no effect.
  assign commit    = (state == RESP);
  assign hit       = (lat_addr[ADDR_WIDTH-1:2] == BASE[ADDR_WIDTH-1:2]);
  assign off       = lat_addr[1:0];
  assign wr_commit = commit && (lat_wr == WR) && hit;
  assign push      = wr_commit && (off == REG_DATA);
  assign flush     = wr_commit && (off == REG_CTRL) && lat_wdata[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      threshold <= '0;
      ovf       <= 1'b0;
    end else begin
      if (wr_commit && (off == REG_CTRL)) threshold <= lat_wdata[CW+3:4];
      // full implies non-empty, so pop_i here is always an effective pop
      if (wr_commit && (off == REG_CLRERR)) ovf <= 1'b0;
      else if (push && full && !pop_i)      ovf <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CW         (CW)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (lat_wdata),
    .pop       (pop_i),
    .flush     (flush),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  // Read mux sees pre-edge state during RESP, so STATUS reflects the FIFO before commit.
  always_comb begin
    rd_mux = '0;
    if (hit) begin
      case (off)
        REG_DATA:   rd_mux = empty ? '0 : head;
        REG_STATUS: rd_mux[CW+2:0] = {count, ovf, full, empty};
        REG_CTRL:   rd_mux[CW+3:4] = threshold;
        default:    rd_mux = '0;
      endcase
    end
  end

  assign bus.ready_o = commit;
  assign bus.rdata_o = (commit && (lat_wr == RD)) ? rd_mux : '0;

  assign pop_valid_o = !empty;
  assign pop_data_o  = empty ? '0 : head;
  assign irq_o       = (threshold != '0) && (count >= threshold);
endmodule

// File: tb/tb_bus_fifo_responder.sv
module tb_bus_fifo_responder;
  import bus_pkg::*;

  localparam logic [9:0] A_DATA   = 10'h3F0;
  localparam logic [9:0] A_STATUS = 10'h3F1;
  localparam logic [9:0] A_CTRL   = 10'h3F2;
  localparam logic [9:0] A_CLRERR = 10'h3F3;

  logic        clk = 1'b0;
  logic        rst;
  logic        pop_i;
  logic [15:0] pop_data;
  logic        pop_valid;
  logic        irq;

  bus_fifo_responder_if #(.ADDR_WIDTH(10), .WIDTH(16)) bus ();

  bus_fifo_responder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .pop_data_o  (pop_data),
    .pop_valid_o (pop_valid),
    .pop_i       (pop_i),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  logic [15:0] sb[$];
  logic        ovf_m;

  typedef struct {
    logic [9:0]  addr;
    logic        wr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus transaction; returns read data and the number of edges until ready_o was seen.
  // pop_resp drives pop_i during the RESP cycle. Returns after the commit edge.
  task automatic txn(input logic [9:0] a, input logic w, input logic [15:0] d,
                     input logic pop_resp, output logic [15:0] rd, output int lat);
    bus.addr_i  = a;
    bus.wr_rd_i = w;
    bus.wdata_i = d;
    bus.valid_i = 1'b1;
    rd  = '0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.ready_o) begin
        lat = i;
        rd  = bus.rdata_o;
        break;
      end
    end
    bus.valid_i = 1'b0;
    pop_i = pop_resp;
    if (lat == 0) check("ready_timeout", 0, 1);
    @(negedge clk);
    pop_i = 1'b0;
  endtask

  task automatic write_data(input logic [15:0] d);
    logic [15:0] rd;
    int lat;
    txn(A_DATA, WR, d, 1'b0, rd, lat);
    if (sb.size() < 8) sb.push_back(d);
    else               ovf_m = 1'b1;
  endtask

  task automatic read_reg(input string name, input logic [9:0] a, input logic [15:0] exp);
    logic [15:0] rd;
    int lat;
    txn(a, RD, 16'h0, 1'b0, rd, lat);
    check(name, rd, exp);
  endtask

  task automatic write_reg(input logic [9:0] a, input logic [15:0] d);
    logic [15:0] rd;
    int lat;
    txn(a, WR, d, 1'b0, rd, lat);
  endtask

  task automatic pop_one(input string name);
    if (sb.size() == 0) begin
      check({name, "_valid_empty"}, pop_valid, 0);
    end else begin
      check({name, "_valid"}, pop_valid, 1);
      check({name, "_data"}, pop_data, sb[0]);
      void'(sb.pop_front());
      pop_i = 1'b1;
      @(negedge clk);
      pop_i = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] rd;
    int lat;

    rst = 1'b1;
    pop_i = 1'b0;
    ovf_m = 1'b0;
    bus.addr_i = A_DATA;
    bus.wr_rd_i = WR;
    bus.wdata_i = 16'hFFFF;
    bus.valid_i = 1'b1;

    // 1: reset held 3 cycles with a request pending
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", bus.ready_o, 0);
      check("rst_pop_valid", pop_valid, 0);
      check("rst_irq", irq, 0);
      check("rst_rdata", bus.rdata_o, 0);
    end
    check("rst_pop_data", pop_data, 0);
    rst = 1'b0;
    bus.valid_i = 1'b0;
    repeat (5) @(negedge clk);

    // 2: latency and single-cycle ready pulse
    bus.addr_i = A_DATA; bus.wr_rd_i = WR; bus.wdata_i = 16'hA5A5; bus.valid_i = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.ready_o) begin lat = i; break; end
    end
    check("lat_edges", lat, 3);
    bus.valid_i = 1'b0;
    @(negedge clk);
    check("lat_ready_single", bus.ready_o, 0);
    check("lat_pop_valid", pop_valid, 1);
    check("lat_pop_data", pop_data, 16'hA5A5);
    pop_i = 1'b1; @(negedge clk); pop_i = 1'b0;
    check("lat_empty_after_pop", pop_valid, 0);

    // Register map vectors
    vecs[0]  = '{A_STATUS, RD, 16'h0,    16'h0001};
    vecs[1]  = '{A_CTRL,   WR, 16'h0050, 16'h0};
    vecs[2]  = '{A_CTRL,   RD, 16'h0,    16'h0050};
    vecs[3]  = '{A_CLRERR, RD, 16'h0,    16'h0};
    vecs[4]  = '{A_STATUS, WR, 16'hFFFF, 16'h0};
    vecs[5]  = '{A_STATUS, RD, 16'h0,    16'h0001};
    vecs[6]  = '{A_DATA,   RD, 16'h0,    16'h0};
    vecs[7]  = '{10'h010,  RD, 16'h0,    16'h0};
    vecs[8]  = '{10'h3EF,  WR, 16'h1234, 16'h0};
    vecs[9]  = '{A_STATUS, RD, 16'h0,    16'h0001};
    vecs[10] = '{A_DATA,   WR, 16'h00BE, 16'h0};
    vecs[11] = '{A_DATA,   RD, 16'h0,    16'h00BE};
    vecs[12] = '{A_STATUS, RD, 16'h0,    16'h0008};
    vecs[13] = '{A_CTRL,   WR, 16'h0001, 16'h0};
    vecs[14] = '{A_STATUS, RD, 16'h0,    16'h0001};
    vecs[15] = '{A_CTRL,   RD, 16'h0,    16'h0000};
    for (int i = 0; i < 16; i++) begin
      txn(vecs[i].addr, vecs[i].wr, vecs[i].wdata, 1'b0, rd, lat);
      check($sformatf("vec%0d_lat", i), lat, 3);
      if (vecs[i].wr == RD) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end

    // 3: fill to full plus one overflow
    for (int i = 0; i < 9; i++) write_data(16'(i));
    read_reg("full_status", A_STATUS, {9'd0, 4'd8, ovf_m, 1'b1, 1'b0});
    for (int i = 0; i < 8; i++) pop_one($sformatf("fill_pop%0d", i));
    read_reg("drained_status", A_STATUS, {9'd0, 4'd0, ovf_m, 1'b0, 1'b1});
    write_reg(A_CLRERR, 16'h0);
    ovf_m = 1'b0;
    read_reg("clrerr_status", A_STATUS, 16'h0001);

    // 4: push into full FIFO while the consumer pops on the RESP cycle
    for (int i = 0; i < 8; i++) write_data(16'h0100 + 16'(i));
    read_reg("full8_status", A_STATUS, 16'h0042);
    check("fullpop_head", pop_data, sb[0]);
    txn(A_DATA, WR, 16'h01FF, 1'b1, rd, lat);
    void'(sb.pop_front());
    sb.push_back(16'h01FF);
    read_reg("fullpop_status", A_STATUS, 16'h0042);
    for (int i = 0; i < 8; i++) pop_one($sformatf("fullpop_drain%0d", i));

    // 5: pointer wrap, flush, threshold interrupt
    for (int i = 0; i < 20; i++) begin
      write_data(16'($urandom));
      pop_one($sformatf("wrap%0d", i));
    end
    for (int i = 0; i < 3; i++) write_data(16'hC000 + 16'(i));
    write_reg(A_CTRL, 16'h0001);
    sb.delete();
    check("flush_pop_valid", pop_valid, 0);
    read_reg("flush_status", A_STATUS, 16'h0001);
    write_reg(A_CTRL, 16'h0030);
    for (int i = 1; i <= 3; i++) begin
      write_data(16'hD000 + 16'(i));
      check($sformatf("irq_after_push%0d", i), irq, (i >= 3) ? 1 : 0);
    end
    pop_one("irq_pop");
    check("irq_fall", irq, 0);

    // 6: unmapped read, then reset during WAIT
    txn(10'h010, RD, 16'h0, 1'b0, rd, lat);
    check("unmapped_lat", lat, 3);
    check("unmapped_rdata", rd, 0);
    for (int i = 0; i < 2; i++) pop_one($sformatf("pre_rst_pop%0d", i));
    bus.addr_i = A_DATA; bus.wr_rd_i = WR; bus.wdata_i = 16'h7777; bus.valid_i = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    bus.valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      check($sformatf("abort_ready%0d", i), bus.ready_o, 0);
    end
    check("abort_no_push", pop_valid, 0);
    txn(A_CTRL, RD, 16'h0, 1'b0, rd, lat);
    check("post_rst_lat", lat, 3);
    check("post_rst_ctrl", rd, 0);
    read_reg("post_rst_status", A_STATUS, 16'h0001);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
